delay_cfg_ctrl: RTL

Configuration controller for the per-channel delay line of the coincidence detector. It accepts host writes of per-channel delay values into a shadow bank. On a commit request it waits until the delay line is provably empty, then updates the active delay bank atomically for all channels, so no in-flight pulse ever sees a mixed or changed delay. It sits between the host register interface and the delay generator's per-channel delay inputs.

---
 rtl/delay_cfg_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/delay_cfg_ctrl.sv
// ============================================================================
// Module      : delay_cfg_ctrl
// Description : Shadow/active delay bank controller. Commits apply atomically
//               once the delay line has been quiet for max(active)+1 cycles.
//               Optional macro COMMIT_TIMEOUT_EN adds a TMO-cycle commit
//               timeout that forces the apply and pulses Flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_cfg_ctrl #(
  parameter int NCHAN = 4,
  parameter int NBITS = 8,
  parameter int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  parameter int TMO   = 1024
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NCHAN-1:0]       Channels,
  input  logic                   WrValid,
  output logic                   WrReady,
  input  logic [CW-1:0]          WrChan,
  input  logic [NBITS-1:0]       WrDelay,
  input  logic                   Commit,
  output logic [NCHAN*NBITS-1:0] Delays,
  output logic                   Busy,
  output logic                   CommitDone,
  output logic                   CfgErr,
  output logic                   Flush
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_APPLY   = 2'd2;
  localparam int         TW         = NBITS + 1;

  logic [1:0]                   state_q, state_d;
  logic [NCHAN-1:0][NBITS-1:0]  shadow_q, shadow_d;
  logic [NCHAN-1:0][NBITS-1:0]  active_q, active_d;
  logic [TW-1:0]                target_q, target_d;
  logic [TW-1:0]                quiet_q, quiet_d;
  logic                         busy_q, busy_d;
  logic                         wr_ready_q, wr_ready_d;
  logic                         done_q, done_d;
  logic                         cfg_err_q, cfg_err_d;

  logic [NBITS-1:0]             max_delay;
  logic [TW-1:0]                max_plus1;
  logic [TW-1:0]                quiet_inc;
  logic                         quiet_now;
  logic                         window_met;
  logic                         tmo_hit;
  logic                         wr_accept;
  logic                         chan_ok;

  // Worst-case residence of a pulse in the line is max(active)+1 cycles.
  always_comb begin
    max_delay = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (active_q[i] > max_delay) max_delay = active_q[i];
    end
  end

  assign max_plus1  = {1'b0, max_delay} + TW'(1);
  assign quiet_now  = (Channels == '0);
  assign quiet_inc  = (&quiet_q) ? quiet_q : quiet_q + TW'(1);
  assign window_met = quiet_now && (quiet_inc >= target_q);
  assign wr_accept  = WrValid && wr_ready_q;
  assign chan_ok    = ({1'b0, WrChan} < (CW+1)'(NCHAN));

`ifdef COMMIT_TIMEOUT_EN
  localparam int MW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  logic [MW-1:0] tmo_q, tmo_d;
  logic          flush_q, flush_d;

  assign tmo_hit = (state_q == ST_PENDING) && (tmo_q == MW'(TMO - 1));

  always_comb begin
    tmo_d   = '0;
    flush_d = 1'b0;
    if (state_q == ST_PENDING) begin
      tmo_d   = tmo_q + MW'(1);
      flush_d = tmo_hit && !window_met;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      flush_q <= flush_d;
    end
  end

  assign Flush = flush_q;
`else
  assign tmo_hit = 1'b0;
  assign Flush   = 1'b0 & (TMO > 0);
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (Commit) state_d = ST_PENDING;
      ST_PENDING: if (window_met || tmo_hit) state_d = ST_APPLY;
      ST_APPLY:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: outputs are registered from the upcoming state
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    wr_ready_d = (state_d == ST_IDLE);
    done_d     = (state_q == ST_APPLY);
  end

  // Shadow/active banks, target and quiet-window counter
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    target_d  = target_q;
    quiet_d   = '0;
    cfg_err_d = cfg_err_q | (wr_accept & ~chan_ok);

    for (int i = 0; i < NCHAN; i++) begin
      if (wr_accept && (WrChan == CW'(i))) shadow_d[i] = WrDelay;
    end

    if ((state_q == ST_IDLE) && Commit) target_d = max_plus1;

    if ((state_q == ST_PENDING) && quiet_now) quiet_d = quiet_inc;

    if (state_q == ST_APPLY) active_d = shadow_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      target_q   <= '0;
      quiet_q    <= '0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      target_q   <= target_d;
      quiet_q    <= quiet_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign Delays     = active_q;
  assign Busy       = busy_q;
  assign WrReady    = wr_ready_q;
  assign CommitDone = done_q;
  assign CfgErr     = cfg_err_q;

endmodule

`default_nettype wire
